fir_lowpass_engine: RTL and testbench

//   Stereo boxcar (moving-average) FIR low-pass stage, upstream of the DSP output/volume stage.
//   One sample pair is accepted per sample_strobe. The block filters it with one shared adder

---
 rtl/fir_lowpass_engine.sv | 130 +++++++++++++
 tb/tb_fir_lowpass_engine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_lowpass_engine.sv
// Stereo boxcar FIR low-pass; one shared adder per channel walks the TAPS-deep delay line.
// Latency: out_valid at edge TAPS+2 after the accepting edge; next strobe accepted on that edge.
// Backpressure: none; strobes that arrive while busy are dropped and flagged in sticky overrun.
// Optional feature: define LPF_BYPASS_EN to add the lpf_bypass input (raw passthrough at DONE).
module fir_lowpass_engine #(
  parameter int TAPS = 8,
  parameter int DW   = 16
) (
  input  logic          CLOCK_50,
  input  logic          AUD_DACLRCK,
  input  logic          sample_strobe,
  input  logic [DW-1:0] audio_inL,
  input  logic [DW-1:0] audio_inR,
`ifdef LPF_BYPASS_EN
  input  logic          lpf_bypass,
`endif
  output logic [DW-1:0] lpf_outL,
  output logic [DW-1:0] lpf_outR,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int SH   = $clog2(TAPS);
  localparam int ACCW = DW + SH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ACC   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0]   lat_l, lat_r;
  logic            lat_byp;
  logic [DW-1:0]   tap_l [TAPS];
  logic [DW-1:0]   tap_r [TAPS];
  logic [ACCW-1:0] acc_l, acc_r;
  logic [SH-1:0]   cnt;
  logic            accept;
  logic            acc_last;
  logic [ACCW-1:0] tap_l_ext, tap_r_ext;

  // A strobe is taken in IDLE or in DONE so back-to-back samples lose no cycle.
  assign accept   = sample_strobe && (state == S_IDLE || state == S_DONE);
  assign acc_last = (cnt == SH'(TAPS - 1));
  assign busy     = (state != S_IDLE);

  // Sign-extend the currently addressed taps to accumulator width.
  assign tap_l_ext = {{SH{tap_l[cnt][DW-1]}}, tap_l[cnt]};
  assign tap_r_ext = {{SH{tap_r[cnt][DW-1]}}, tap_r[cnt]};

  // State register; reset aborts any sample in flight.
  always_ff @(posedge CLOCK_50 or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) state <= S_IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic for the IDLE -> SHIFT -> ACC -> DONE sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = S_ACC;
      S_ACC:   if (acc_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = accept ? S_SHIFT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-sample control: input latch, accumulators, tap counter, flags.
  always_ff @(posedge CLOCK_50 or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      lat_l     <= '0;
      lat_r     <= '0;
      lat_byp   <= 1'b0;
      acc_l     <= '0;
      acc_r     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= (state == S_DONE);
      if (accept) begin
        lat_l <= audio_inL;
        lat_r <= audio_inR;
`ifdef LPF_BYPASS_EN
        lat_byp <= lpf_bypass;
`else
        lat_byp <= 1'b0;
`endif
      end
      if (sample_strobe && (state == S_SHIFT || state == S_ACC))
        overrun <= 1'b1;
      case (state)
        S_SHIFT: begin
          acc_l <= '0;
          acc_r <= '0;
          cnt   <= '0;
        end
        S_ACC: begin
          acc_l <= acc_l + tap_l_ext;
          acc_r <= acc_r + tap_r_ext;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // History and output registers are deliberately unreset so they survive the frame reset.
  always_ff @(posedge CLOCK_50) begin
    if (state == S_SHIFT) begin
      tap_l[0] <= lat_l;
      tap_r[0] <= lat_r;
      for (int k = 1; k < TAPS; k++) begin
        tap_l[k] <= tap_l[k-1];
        tap_r[k] <= tap_r[k-1];
      end
    end
    if (state == S_DONE) begin
      // Dropping the low SH bits of a signed sum is a floor divide by TAPS.
      lpf_outL <= lat_byp ? lat_l : acc_l[ACCW-1:SH];
      lpf_outR <= lat_byp ? lat_r : acc_r[ACCW-1:SH];
    end
  end

endmodule

// File: tb/tb_fir_lowpass_engine.sv
// Directed bench for fir_lowpass_engine at TAPS=8, DW=16.
// Inputs driven away from the rising edge; outputs sampled 1ns after it.
// Each scenario task does its own comparisons against hand-computed values.
module tb_fir_lowpass_engine;

  logic        CLOCK_50 = 1'b0;
  logic        AUD_DACLRCK = 1'b1;
  logic        sample_strobe = 1'b0;
  logic [15:0] audio_inL = '0;
  logic [15:0] audio_inR = '0;
  logic        lpf_bypass = 1'b0;
  logic [15:0] lpf_outL, lpf_outR;
  logic        out_valid, busy, overrun;

  int compared = 0;
  int mismatched = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  fir_lowpass_engine #(.TAPS(8), .DW(16)) dut (
    .CLOCK_50      (CLOCK_50),
    .AUD_DACLRCK   (AUD_DACLRCK),
    .sample_strobe (sample_strobe),
    .audio_inL     (audio_inL),
    .audio_inR     (audio_inR),
`ifdef LPF_BYPASS_EN
    .lpf_bypass    (lpf_bypass),
`endif
    .lpf_outL      (lpf_outL),
    .lpf_outR      (lpf_outR),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  // Stimulus only: one strobe, optional second strobe at edge second_at, observe edges 1..11.
  task automatic send(input logic [15:0] l, input logic [15:0] r, input int second_at,
                      output int vld_cnt, output int vld_edge, output int busy_bad);
    @(negedge CLOCK_50);
    audio_inL = l;
    audio_inR = r;
    sample_strobe = 1'b1;
    @(posedge CLOCK_50); #1;
    sample_strobe = 1'b0;
    vld_cnt = 0; vld_edge = -1; busy_bad = 0;
    if (busy !== 1'b1) busy_bad++;
    for (int k = 1; k <= 11; k++) begin
      sample_strobe = (k == second_at);
      @(posedge CLOCK_50); #1;
      if (out_valid === 1'b1) begin
        vld_cnt++;
        vld_edge = k;
      end
      if (busy !== ((k < 10) ? 1'b1 : 1'b0)) busy_bad++;
    end
    sample_strobe = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    AUD_DACLRCK = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1 AUD_DACLRCK = 1'b0;
  endtask

  task automatic prime_zeros();
    int c, e, b;
    for (int i = 0; i < 8; i++) send(16'h0000, 16'h0000, 0, c, e, b);
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", out_valid); end
    compared++;
    if (overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun got %b want 0", overrun); end
  endtask

  task automatic test_step();
    int c, e, b;
    prime_zeros();
    send(16'h0800, 16'hF800, 0, c, e, b);
    compared++;
    if (c !== 1) begin mismatched++; $display("FAIL t1_valid_count got %0d want 1", c); end
    compared++;
    if (e !== 10) begin mismatched++; $display("FAIL t1_valid_edge got %0d want 10", e); end
    compared++;
    if (b !== 0) begin mismatched++; $display("FAIL t1_busy_profile got %0d bad edges want 0", b); end
    compared++;
    if (lpf_outL !== 16'h0100) begin mismatched++; $display("FAIL t1_outL got %h want 0100", lpf_outL); end
    compared++;
    if (lpf_outR !== 16'hFF00) begin mismatched++; $display("FAIL t1_outR got %h want ff00", lpf_outR); end
  endtask

  task automatic test_ramp();
    int c, e, b;
    logic [15:0] want;
    for (int i = 0; i < 7; i++) begin
      send(16'h0800, 16'hF800, 0, c, e, b);
      want = 16'(16'h0100 * (i + 2));
      compared++;
      if (lpf_outL !== want) begin mismatched++; $display("FAIL t2_outL step %0d got %h want %h", i, lpf_outL, want); end
    end
    compared++;
    if (lpf_outR !== 16'hF800) begin mismatched++; $display("FAIL t2_final_outR got %h want f800", lpf_outR); end
  endtask

  task automatic test_floor();
    int c, e, b;
    prime_zeros();
    send(16'hFFFF, 16'h0007, 0, c, e, b);
    compared++;
    if (lpf_outL !== 16'hFFFF) begin mismatched++; $display("FAIL t3_outL got %h want ffff", lpf_outL); end
    compared++;
    if (lpf_outR !== 16'h0000) begin mismatched++; $display("FAIL t3_outR got %h want 0000", lpf_outR); end
  endtask

  task automatic test_overrun();
    int c, e, b;
    do_reset();
    send(16'h0800, 16'h0000, 4, c, e, b);
    compared++;
    if (c !== 1) begin mismatched++; $display("FAIL t4_valid_count got %0d want 1", c); end
    compared++;
    if (e !== 10) begin mismatched++; $display("FAIL t4_valid_edge got %0d want 10", e); end
    compared++;
    if (b !== 0) begin mismatched++; $display("FAIL t4_busy_profile got %0d bad edges want 0", b); end
    compared++;
    if (overrun !== 1'b1) begin mismatched++; $display("FAIL t4_overrun_set got %b want 1", overrun); end
    send(16'h0000, 16'h0000, 0, c, e, b);
    compared++;
    if (overrun !== 1'b1) begin mismatched++; $display("FAIL t4_overrun_sticky got %b want 1", overrun); end
    do_reset();
    compared++;
    if (overrun !== 1'b0) begin mismatched++; $display("FAIL t4_overrun_cleared got %b want 0", overrun); end
  endtask

  task automatic test_reset_mid();
    int c, e, b, vc, bb;
    prime_zeros();
    @(negedge CLOCK_50);
    audio_inL = 16'h0800;
    audio_inR = 16'h0000;
    sample_strobe = 1'b1;
    @(posedge CLOCK_50); #1;
    sample_strobe = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #1 AUD_DACLRCK = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1 AUD_DACLRCK = 1'b0;
    vc = 0; bb = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge CLOCK_50); #1;
      if (out_valid === 1'b1) vc++;
      if (busy !== 1'b0) bb++;
    end
    compared++;
    if (vc !== 0) begin mismatched++; $display("FAIL t5_no_valid got %0d pulses want 0", vc); end
    compared++;
    if (bb !== 0) begin mismatched++; $display("FAIL t5_busy_low got %0d busy cycles want 0", bb); end
    compared++;
    if (lpf_outL !== 16'h0000) begin mismatched++; $display("FAIL t5_outL_held got %h want 0000", lpf_outL); end
    send(16'h0000, 16'h0000, 0, c, e, b);
    compared++;
    if (lpf_outL !== 16'h0100) begin mismatched++; $display("FAIL t5_history_kept got %h want 0100", lpf_outL); end
  endtask

  task automatic test_back_to_back();
    int vc, e1, e2;
    logic b10;
    logic [15:0] o1, o2;
    do_reset();
    prime_zeros();
    @(negedge CLOCK_50);
    audio_inL = 16'h0800;
    audio_inR = 16'h0000;
    sample_strobe = 1'b1;
    @(posedge CLOCK_50); #1;
    vc = 0; e1 = -1; e2 = -1; b10 = 1'b0; o1 = '0; o2 = '0;
    for (int k = 1; k <= 21; k++) begin
      sample_strobe = (k == 10);
      @(posedge CLOCK_50); #1;
      if (k == 10) b10 = busy;
      if (out_valid === 1'b1) begin
        vc++;
        if (e1 < 0) begin e1 = k; o1 = lpf_outL; end
        else begin e2 = k; o2 = lpf_outL; end
      end
    end
    sample_strobe = 1'b0;
    compared++;
    if (vc !== 2) begin mismatched++; $display("FAIL b2b_valid_count got %0d want 2", vc); end
    compared++;
    if (e1 !== 10 || e2 !== 20) begin mismatched++; $display("FAIL b2b_edges got %0d,%0d want 10,20", e1, e2); end
    compared++;
    if (b10 !== 1'b1) begin mismatched++; $display("FAIL b2b_busy_edge10 got %b want 1", b10); end
    compared++;
    if (o1 !== 16'h0100 || o2 !== 16'h0200) begin mismatched++; $display("FAIL b2b_outputs got %h,%h want 0100,0200", o1, o2); end
    compared++;
    if (overrun !== 1'b0) begin mismatched++; $display("FAIL b2b_no_overrun got %b want 0", overrun); end
  endtask

`ifdef LPF_BYPASS_EN
  task automatic test_bypass();
    int c, e, b;
    prime_zeros();
    lpf_bypass = 1'b1;
    send(16'h1234, 16'h8000, 0, c, e, b);
    lpf_bypass = 1'b0;
    compared++;
    if (e !== 10) begin mismatched++; $display("FAIL t6_valid_edge got %0d want 10", e); end
    compared++;
    if (lpf_outL !== 16'h1234 || lpf_outR !== 16'h8000) begin
      mismatched++; $display("FAIL t6_raw got %h,%h want 1234,8000", lpf_outL, lpf_outR);
    end
    send(16'h0000, 16'h0000, 0, c, e, b);
    compared++;
    if (lpf_outL !== 16'h0246 || lpf_outR !== 16'hF000) begin
      mismatched++; $display("FAIL t6_filtered got %h,%h want 0246,f000", lpf_outL, lpf_outR);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_step();
    test_ramp();
    test_floor();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
`ifdef LPF_BYPASS_EN
    test_bypass();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
